// File: rtl/uart_tx.sv
// UART transmitter driven by an external one-cycle baud strobe.
// Sends LSB-first frames: start, DATA_BITS data, optional parity, 1..2 stop bits.
module uart_tx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned    IdxW     = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic           StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StStart,
    StData,
    StPar,
    StStop
  } state_e;

  state_e                 state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [IdxW-1:0]        bit_idx_q;
  logic                   stop_q;
  logic                   par_q;
  logic                   txd_q;
  logic                   done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (in_valid) begin
            shift_q <= in_data;
            // Parity is taken from the whole word here, before any shifting.
            par_q   <= (^in_data) ^ (PARITY == 2);
            state_q <= StSync;
          end
        end
        StSync: begin
          if (baud_tick) begin
            txd_q   <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_tick) begin
            txd_q     <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (baud_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_idx_q == LastIdx) begin
              if (PARITY != 0) begin
                txd_q   <= par_q;
                state_q <= StPar;
              end else begin
                txd_q   <= 1'b1;
                stop_q  <= 1'b0;
                state_q <= StStop;
              end
            end else begin
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        StPar: begin
          if (baud_tick) begin
            txd_q   <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (baud_tick) begin
            if (stop_q == StopLast) begin
              stop_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = !in_ready;
  assign txd      = txd_q;
  assign done     = done_q;

endmodule
